// File: rtl/q_op_vec_builder.sv
// ============================================================================
//  Module   : q_op_vec_builder
//  Purpose  : Builds the per-qubit op vector (OPW bits per qubit) from either
//             a single-qubit bitmap (short offset form or long full form) or
//             a two-qubit pair list (one short pair or NPAIR long pairs).
//             Short requests and single-qubit requests complete at the accept
//             edge. Long pair lists take one pair per cycle, so they complete
//             a fixed NPAIR edges after accept. Indices >= NQ are dropped and
//             raise out_err.
//  Ports    : clk, rst (sync, active high)
//             in_valid/in_ready     request handshake
//             in_mode, in_long      request kind (01 single, 10 double)
//             in_off, in_sbits_s    short single (qubit = OFF_STEP*off + k)
//             in_sbits_l            long single (bit i -> qubit i)
//             in_pair_s             short pair {tgt, ctl}
//             in_pair_l, in_pmask   long pairs and their enables
//             out_valid/out_ready   result handshake
//             out_op, out_err       op vector (qubit q at [OPW*q +: OPW]),
//                                   transaction error flag
//  Config   : Q_OP_CONFLICT_CHK_EN - in double mode, also flag writes to a
//             slot that is already non-zero in this transaction, and ctl==tgt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_op_vec_builder #(
    parameter int NQ       = 110,
    parameter int OPW      = 2,
    parameter int SHORT_W  = 46,
    parameter int OFF_STEP = 4,
    parameter int OFF_W    = 5,
    parameter int NPAIR    = 7,
    parameter int QIDX_W   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_mode,
    input  logic                        in_long,
    input  logic [OFF_W-1:0]            in_off,
    input  logic [SHORT_W-1:0]          in_sbits_s,
    input  logic [NQ-1:0]               in_sbits_l,
    input  logic [2*QIDX_W-1:0]         in_pair_s,
    input  logic [NPAIR*2*QIDX_W-1:0]   in_pair_l,
    input  logic [NPAIR-1:0]            in_pmask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NQ*OPW-1:0]           out_op,
    output logic                        out_err
);

    localparam int c_IW = $clog2(NQ);
    localparam int c_CW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int c_PW = 2 * QIDX_W;
    localparam logic [OPW-1:0] c_CTL = OPW'(2'b10);
    localparam logic [OPW-1:0] c_TGT = OPW'(2'b01);

    typedef logic [NQ-1:0][OPW-1:0] t_vec;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } t_state;

    t_state                       r_state;
    logic [c_CW-1:0]              r_cnt;
    t_vec                         r_acc;
    logic                         r_acc_err;
    logic [NPAIR-1:0][c_PW-1:0]   r_pairs;
    logic [NPAIR-1:0]             r_pmask;

    t_vec                         w_imm_vec;
    logic                         w_imm_err;
    t_vec                         w_pair_vec;
    logic                         w_pair_err;
    t_vec                         w_walk_vec;
    logic                         w_walk_err;
    logic                         w_accept;
    logic                         w_walk_req;
    logic                         w_last;

    // Apply one (ctl, tgt) pair to a vector. ctl is written before tgt so a
    // ctl==tgt pair leaves the target code in the slot.
    function automatic void f_apply_pair(
        input  t_vec             vin,
        input  logic [c_PW-1:0]  pair,
        output t_vec             vout,
        output logic             err
    );
        int ctl_i;
        int tgt_i;
        vout  = vin;
        err   = 1'b0;
        ctl_i = int'(pair[QIDX_W-1:0]);
        tgt_i = int'(pair[c_PW-1:QIDX_W]);
        if (ctl_i < NQ) begin
`ifdef Q_OP_CONFLICT_CHK_EN
            if (vout[c_IW'(ctl_i)] != '0) err = 1'b1;
`endif
            vout[c_IW'(ctl_i)] = c_CTL;
        end else begin
            err = 1'b1;
        end
        if (tgt_i < NQ) begin
`ifdef Q_OP_CONFLICT_CHK_EN
            if (vout[c_IW'(tgt_i)] != '0) err = 1'b1;
`endif
            vout[c_IW'(tgt_i)] = c_TGT;
        end else begin
            err = 1'b1;
        end
`ifdef Q_OP_CONFLICT_CHK_EN
        if (ctl_i == tgt_i) err = 1'b1;
`endif
    endfunction

    assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_walk_req = (in_mode == 2'b10) && in_long;
    assign w_last     = (r_cnt == c_CW'(NPAIR - 1));

    // Result for requests that complete on the accept edge.
    always_comb begin
        w_imm_vec  = '0;
        w_imm_err  = 1'b0;
        w_pair_vec = '0;
        w_pair_err = 1'b0;
        f_apply_pair('0, in_pair_s, w_pair_vec, w_pair_err);
        case (in_mode)
            2'b01: begin
                if (in_long) begin
                    for (int q = 0; q < NQ; q++) begin
                        w_imm_vec[q] = {OPW{in_sbits_l[q]}};
                    end
                end else begin
                    for (int k = 0; k < SHORT_W; k++) begin
                        int idx;
                        idx = OFF_STEP * int'(in_off) + k;
                        if (in_sbits_s[k]) begin
                            if (idx < NQ) w_imm_vec[c_IW'(idx)] = '1;
                            else          w_imm_err = 1'b1;
                        end
                    end
                end
            end
            2'b10: begin
                w_imm_vec = w_pair_vec;
                w_imm_err = w_pair_err;
            end
            default: ;
        endcase
    end

    // One long-list pair per cycle; masked pairs pass the accumulator through.
    always_comb begin
        w_walk_vec = r_acc;
        w_walk_err = 1'b0;
        if (r_pmask[r_cnt]) begin
            f_apply_pair(r_acc, r_pairs[r_cnt], w_walk_vec, w_walk_err);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_err <= 1'b0;
            r_pairs   <= '0;
            r_pmask   <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if ((r_state == S_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_acc_err <= 1'b0;
                        r_pairs   <= in_pair_l;
                        r_pmask   <= in_pmask;
                        if (w_walk_req) begin
                            r_state <= S_WALK;
                        end else begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            out_op    <= w_imm_vec;
                            out_err   <= w_imm_err;
                        end
                    end
                end
                S_WALK: begin
                    r_acc     <= w_walk_vec;
                    r_acc_err <= r_acc_err | w_walk_err;
                    r_cnt     <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        out_op    <= w_walk_vec;
                        out_err   <= r_acc_err | w_walk_err;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
